// File: rtl/conv2_feeder_pkg.sv
// Shared CNN package: pool1/conv2 feature-map geometry and the conv2 feeder state encoding.
package conv2_feeder_pkg;

   localparam int CNN_IMG_W = 12;
   localparam int CNN_IMG_H = 12;
   localparam int CNN_CH    = 6;
   localparam int CNN_DW    = 16;

   typedef enum logic [1:0] {
      FILL,
      PREF,
      SEND
   } feeder_state_t;

endpackage

// File: rtl/feeder_ram.sv
// Simple dual-port synchronous RAM: one write port and one registered read port.
module feeder_ram #(
   parameter int W     = 96,
   parameter int DEPTH = 144,
   parameter int AW    = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [W-1:0]  i_wdata,
   input  logic          i_re,
   input  logic [AW-1:0] i_raddr,
   output logic [W-1:0]  o_rdata
);

   logic [W-1:0] r_mem [DEPTH];
   logic [W-1:0] r_rdata;

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   // Only the read register is reset; it doubles as the feeder's data_out.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rdata <= '0;
      end else if (i_re) begin
         r_rdata <= r_mem[i_raddr];
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/conv2_feeder.sv
// Frame buffer feeding conv2: stores a pool1 frame, then replays it gated by c2_ready.
// CONV2_FEEDER_PINGPONG_EN selects a two-bank build where fill of one bank overlaps send of the other.
module conv2_feeder
   import conv2_feeder_pkg::*;
#(
   parameter int IMG_W = CNN_IMG_W,
   parameter int IMG_H = CNN_IMG_H,
   parameter int CH    = CNN_CH,
   parameter int DW    = CNN_DW
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [DW*CH-1:0] wr_data,
   input  logic             wr_valid,
   input  logic             wr_sof,
   output logic             wr_ready,
   input  logic             c2_ready,
   output logic [DW*CH-1:0] data_out,
   output logic             data_out_valid,
   output logic             frame_done,
   output logic             busy
);

   localparam int N  = IMG_W * IMG_H;
   localparam int AW = $clog2(N);
   localparam int PW = DW * CH;
   localparam logic [AW-1:0] LAST = AW'(N - 1);

   feeder_state_t r_state;
   feeder_state_t w_state_nxt;

   logic [AW-1:0] r_wr_cnt;
   logic [AW-1:0] r_rd_idx;
   logic [AW-1:0] w_wr_addr;
   logic [AW-1:0] w_rd_addr;
   logic          w_wr_ready;
   logic          w_wr_fire;
   logic          w_fill_done;
   logic          w_tx;
   logic          w_last_tx;
   logic          w_rd_en;
   logic          w_start;
   logic          w_chain;

   // A start-of-frame write always lands at address 0, abandoning any partial frame.
   assign w_wr_fire   = wr_valid & w_wr_ready;
   assign w_wr_addr   = wr_sof ? '0 : r_wr_cnt;
   assign w_fill_done = w_wr_fire & (w_wr_addr == LAST);

   assign w_tx      = (r_state == SEND) & c2_ready;
   assign w_last_tx = w_tx & (r_rd_idx == LAST);
   assign w_rd_en   = (r_state == PREF) | (w_tx & ~w_last_tx);
   assign w_rd_addr = (r_state == PREF) ? '0 : r_rd_idx + 1'b1;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_cnt <= '0;
      end else if (w_wr_fire) begin
         r_wr_cnt <= (w_wr_addr == LAST) ? '0 : w_wr_addr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rd_idx <= '0;
      end else if (r_state == PREF) begin
         r_rd_idx <= '0;
      end else if (w_tx) begin
         r_rd_idx <= w_last_tx ? '0 : r_rd_idx + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= FILL;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         FILL:    if (w_start) w_state_nxt = PREF;
         PREF:    w_state_nxt = SEND;
         SEND:    if (w_last_tx) w_state_nxt = w_chain ? PREF : FILL;
         default: w_state_nxt = FILL;
      endcase
   end

`ifdef CONV2_FEEDER_PINGPONG_EN
   logic [1:0]    r_full;
   logic [1:0]    w_full_nxt;
   logic          r_wbank;
   logic          r_rbank;
   logic          r_obank;
   logic [PW-1:0] w_rdata [2];

   // A bank completing its fill this cycle already counts as FULL for starting a send.
   assign w_wr_ready = ~r_full[r_wbank];
   assign w_start    = r_full[r_rbank] | (w_fill_done & (r_wbank == r_rbank));
   assign w_chain    = r_full[~r_rbank] | (w_fill_done & (r_wbank != r_rbank));

   always_comb begin
      w_full_nxt = r_full;
      if (w_last_tx) w_full_nxt[r_rbank] = 1'b0;
      if (w_fill_done) w_full_nxt[r_wbank] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_full  <= '0;
         r_wbank <= 1'b0;
         r_rbank <= 1'b0;
         r_obank <= 1'b0;
      end else begin
         r_full <= w_full_nxt;
         if (w_fill_done) r_wbank <= ~r_wbank;
         if (w_last_tx) r_rbank <= ~r_rbank;
         if (w_rd_en) r_obank <= r_rbank;
      end
   end

   for (genvar b = 0; b < 2; b++) begin : g_bank
      feeder_ram #(
         .W     (PW),
         .DEPTH (N),
         .AW    (AW)
      ) u_ram (
         .clk     (clk),
         .rst     (rst),
         .i_we    (w_wr_fire & (r_wbank == 1'(b))),
         .i_waddr (w_wr_addr),
         .i_wdata (wr_data),
         .i_re    (w_rd_en & (r_rbank == 1'(b))),
         .i_raddr (w_rd_addr),
         .o_rdata (w_rdata[b])
      );
   end

   assign data_out = w_rdata[r_obank];
`else
   logic [PW-1:0] w_rdata;

   assign w_wr_ready = (r_state == FILL);
   assign w_start    = w_fill_done;
   assign w_chain    = 1'b0;

   feeder_ram #(
      .W     (PW),
      .DEPTH (N),
      .AW    (AW)
   ) u_ram (
      .clk     (clk),
      .rst     (rst),
      .i_we    (w_wr_fire),
      .i_waddr (w_wr_addr),
      .i_wdata (wr_data),
      .i_re    (w_rd_en),
      .i_raddr (w_rd_addr),
      .o_rdata (w_rdata)
   );

   assign data_out = w_rdata;
`endif

   assign wr_ready       = w_wr_ready;
   assign data_out_valid = w_tx;
   assign frame_done     = w_last_tx;
   assign busy           = (r_state == SEND);

endmodule
